// File: rtl/llc_req_arbiter.sv
// rtl/llc_req_arbiter.sv - snoop-priority request arbiter/sequencer for the LLC command port
// Optional statistics counters are built when ARB_STATS_EN is defined.
module llc_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [3:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [3:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              llc_valid,
  output logic [3:0]        llc_op,
  output logic [ADDR_W-1:0] llc_addr,
  input  logic              llc_hold,
  output logic              grant_snp,
  output logic              err_illegal,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       stat_cpu_grants,
  output logic [31:0]       stat_snp_grants,
  output logic [31:0]       stat_hold_cycles,
  output logic [31:0]       stat_illegal
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

  state_t state, state_nxt;

  logic [3:0]        cpu_op_mem   [FIFO_DEPTH];
  logic [ADDR_W-1:0] cpu_addr_mem [FIFO_DEPTH];
  logic [3:0]        snp_op_mem   [FIFO_DEPTH];
  logic [ADDR_W-1:0] snp_addr_mem [FIFO_DEPTH];

  logic [PW-1:0] cpu_wr, cpu_rd, snp_wr, snp_rd;
  logic [PW-1:0] cpu_cnt, snp_cnt, cpu_cnt_eff, snp_cnt_eff;
  logic [AW-1:0] cpu_head_idx, snp_head_idx;
  logic          cpu_full, snp_full;
  logic          cpu_hs, snp_hs, cpu_legal, snp_legal, cpu_push, snp_push;
  logic          pop_cpu, pop_snp;
  logic          barrier_clear, cpu_elig, snp_elig, starved;
  logic          pick_cpu, pick_snp;
  logic [3:0]    cpu_head_op;
  logic [SW-1:0] starve_cnt, starve_nxt;

  function automatic logic is_cpu_op(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd8) || (op == 4'd9);
  endfunction

  function automatic logic is_snp_op(input logic [3:0] op);
    return (op == 4'd3) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
  endfunction

  assign cpu_full  = (cpu_wr[PW-1] != cpu_rd[PW-1]) && (cpu_wr[AW-1:0] == cpu_rd[AW-1:0]);
  assign snp_full  = (snp_wr[PW-1] != snp_rd[PW-1]) && (snp_wr[AW-1:0] == snp_rd[AW-1:0]);
  assign cpu_ready = !cpu_full;
  assign snp_ready = !snp_full;
  assign cpu_cnt   = cpu_wr - cpu_rd;
  assign snp_cnt   = snp_wr - snp_rd;

  assign cpu_hs    = cpu_valid && cpu_ready;
  assign snp_hs    = snp_valid && snp_ready;
  assign cpu_legal = is_cpu_op(cpu_op);
  assign snp_legal = is_snp_op(snp_op);
  assign cpu_push  = cpu_hs && cpu_legal;
  assign snp_push  = snp_hs && snp_legal;

  // The issuing entry stays at the head until the end of ISSUE, so the next
  // winner is chosen from the view with that entry already removed.
  assign pop_cpu      = (state == S_ISSUE) && !grant_snp;
  assign pop_snp      = (state == S_ISSUE) && grant_snp;
  assign cpu_cnt_eff  = cpu_cnt - PW'(pop_cpu);
  assign snp_cnt_eff  = snp_cnt - PW'(pop_snp);
  assign cpu_head_idx = cpu_rd[AW-1:0] + AW'(pop_cpu);
  assign snp_head_idx = snp_rd[AW-1:0] + AW'(pop_snp);
  assign cpu_head_op  = cpu_op_mem[cpu_head_idx];

  assign barrier_clear = (snp_cnt == '0) && !((state != S_IDLE) && grant_snp);
  assign cpu_elig      = (cpu_cnt_eff != '0) &&
                         (!((cpu_head_op == 4'd8) || (cpu_head_op == 4'd9)) || barrier_clear);
  assign snp_elig      = (snp_cnt_eff != '0);
  assign starved       = (starve_cnt == SW'(STARVE_LIMIT));

  always_comb begin
    state_nxt = state;
    pick_cpu  = 1'b0;
    pick_snp  = 1'b0;
    case (state)
      S_ISSUE: begin
        if (llc_hold) begin
          state_nxt = S_HOLD;
        end else begin
          pick_cpu  = cpu_elig && (starved || !snp_elig);
          pick_snp  = snp_elig && !pick_cpu;
          state_nxt = (pick_cpu || pick_snp) ? S_ISSUE : S_IDLE;
        end
      end
      default: begin
        pick_cpu  = cpu_elig && (starved || !snp_elig);
        pick_snp  = snp_elig && !pick_cpu;
        state_nxt = (pick_cpu || pick_snp) ? S_ISSUE : S_IDLE;
      end
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pick_cpu) begin
      starve_nxt = '0;
    end else if (cpu_cnt_eff == '0) begin
      starve_nxt = '0;
    end else if (pick_snp && !starved) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_wr <= '0;
      cpu_rd <= '0;
      snp_wr <= '0;
      snp_rd <= '0;
    end else begin
      cpu_wr <= cpu_wr + PW'(cpu_push);
      cpu_rd <= cpu_rd + PW'(pop_cpu);
      snp_wr <= snp_wr + PW'(snp_push);
      snp_rd <= snp_rd + PW'(pop_snp);
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_push) begin
      cpu_op_mem[cpu_wr[AW-1:0]]   <= cpu_op;
      cpu_addr_mem[cpu_wr[AW-1:0]] <= cpu_addr;
    end
    if (snp_push) begin
      snp_op_mem[snp_wr[AW-1:0]]   <= snp_op;
      snp_addr_mem[snp_wr[AW-1:0]] <= snp_addr;
    end
  end

  // op/addr only change on a grant, so HOLD and IDLE keep the last command visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llc_op      <= '0;
      llc_addr    <= '0;
      grant_snp   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      err_illegal <= (cpu_hs && !cpu_legal) || (snp_hs && !snp_legal);
      if (pick_cpu) begin
        llc_op    <= cpu_head_op;
        llc_addr  <= cpu_addr_mem[cpu_head_idx];
        grant_snp <= 1'b0;
      end else if (pick_snp) begin
        llc_op    <= snp_op_mem[snp_head_idx];
        llc_addr  <= snp_addr_mem[snp_head_idx];
        grant_snp <= 1'b1;
      end
    end
  end

  assign llc_valid = (state == S_ISSUE);
  assign busy      = (cpu_cnt != '0) || (snp_cnt != '0) || (state != S_IDLE);

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cpu_grants  <= '0;
      stat_snp_grants  <= '0;
      stat_hold_cycles <= '0;
      stat_illegal     <= '0;
    end else begin
      if (pop_cpu && (stat_cpu_grants != '1))
        stat_cpu_grants <= stat_cpu_grants + 32'd1;
      if (pop_snp && (stat_snp_grants != '1))
        stat_snp_grants <= stat_snp_grants + 32'd1;
      if ((state == S_HOLD) && (stat_hold_cycles != '1))
        stat_hold_cycles <= stat_hold_cycles + 32'd1;
      if (err_illegal && (stat_illegal != '1))
        stat_illegal <= stat_illegal + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// tb/tb_llc_req_arbiter.sv - self-checking bench for llc_req_arbiter
module tb_llc_req_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 3;

  logic        clk, rst_n;
  logic        cpu_valid, cpu_ready, snp_valid, snp_ready;
  logic [3:0]  cpu_op, snp_op, llc_op;
  logic [31:0] cpu_addr, snp_addr, llc_addr;
  logic        llc_valid, llc_hold, grant_snp, err_illegal, busy;

  int checks = 0;
  int errors = 0;

  llc_req_arbiter #(.ADDR_W(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
    .llc_valid(llc_valid), .llc_op(llc_op), .llc_addr(llc_addr), .llc_hold(llc_hold),
    .grant_snp(grant_snp), .err_illegal(err_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_valid = 0; cpu_op = 0; cpu_addr = 0;
    snp_valid = 0; snp_op = 0; snp_addr = 0;
    llc_hold = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, " llc_valid"}, 32'(llc_valid), 0);
    chk({tag, " llc_op"}, 32'(llc_op), 0);
    chk({tag, " llc_addr"}, llc_addr, 0);
    chk({tag, " grant_snp"}, 32'(grant_snp), 0);
    chk({tag, " err_illegal"}, 32'(err_illegal), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " cpu_ready"}, 32'(cpu_ready), 1);
    chk({tag, " snp_ready"}, 32'(snp_ready), 1);
  endtask

  // Reference model: two command queues plus the in-flight command.
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] addr;
  } cmd_t;

  cmd_t        cq[$], sq[$];
  bit          m_issue, m_hold, m_snp, m_err;
  logic [3:0]  m_op;
  logic [31:0] m_addr;
  int          m_starve;

  task automatic model_reset();
    cq.delete(); sq.delete();
    m_issue = 0; m_hold = 0; m_snp = 0; m_err = 0;
    m_op = 0; m_addr = 0; m_starve = 0;
  endtask

  task automatic model_edge();
    bit c_rdy, s_rdy, c_legal, s_legal, c_ok, s_ok, pc, ps, snp_inflight;
    cmd_t nc;
    c_rdy   = cq.size() < DEPTH;
    s_rdy   = sq.size() < DEPTH;
    c_legal = cpu_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
    s_legal = snp_op inside {4'd3, 4'd4, 4'd5, 4'd6};
    m_err   = (cpu_valid && c_rdy && !c_legal) || (snp_valid && s_rdy && !s_legal);
    snp_inflight = (m_issue || m_hold) && m_snp;
    if (m_issue) begin
      if (m_snp) sq.delete(0);
      else cq.delete(0);
    end
    pc = 0; ps = 0;
    if (m_issue && llc_hold) begin
      m_issue = 0;
      m_hold  = 1;
    end else begin
      c_ok = (cq.size() > 0) &&
             (!(cq[0].op == 4'd8 || cq[0].op == 4'd9) || (sq.size() == 0 && !snp_inflight));
      s_ok = sq.size() > 0;
      if (c_ok && (m_starve == LIMIT || !s_ok)) pc = 1;
      else if (s_ok) ps = 1;
      if (pc) begin m_op = cq[0].op; m_addr = cq[0].addr; m_snp = 0; end
      if (ps) begin m_op = sq[0].op; m_addr = sq[0].addr; m_snp = 1; end
      m_issue = pc || ps;
      m_hold  = 0;
    end
    if (pc || cq.size() == 0) m_starve = 0;
    else if (ps) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
    if (cpu_valid && c_rdy && c_legal) begin nc.op = cpu_op; nc.addr = cpu_addr; cq.push_back(nc); end
    if (snp_valid && s_rdy && s_legal) begin nc.op = snp_op; nc.addr = snp_addr; sq.push_back(nc); end
  endtask

  typedef struct {
    logic        cv; logic [3:0] cop; logic [31:0] ca;
    logic        sv; logic [3:0] sop; logic [31:0] sa;
    logic        hold;
    logic        e_valid; logic [3:0] e_op; logic [31:0] e_addr;
    logic        e_gs; logic e_err; logic e_busy; logic e_crdy;
  } vec_t;

  vec_t vecs[21];
  int   got_gs[$];
  logic [31:0] got_addr[$];
  bit   exp_gs[7];
  logic [31:0] exp_addr[7];
  logic [3:0] cpu_pool[11];
  logic [3:0] snp_pool[11];

  initial begin
    //           cv    cop   ca          sv    sop   sa          hd  | vld   op    addr        gs    err   busy  crdy
    vecs[0]  = '{1'b1, 4'd0, 32'h1000, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd0, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 4'd1, 32'h2000, 1'b1, 4'd3, 32'h3000, 1'b0, 1'b0, 4'd0, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd3, 32'h3000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd1, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd2, 32'h4000, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'd0, 32'h5000, 1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd2, 32'h4000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b1, 1'b0, 4'd2, 32'h4000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b1, 1'b1, 4'd0, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd0, 32'h5000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 4'd8, 32'h7000, 1'b1, 4'd4, 32'h6000, 1'b0, 1'b0, 4'd0, 32'h5000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd4, 32'h6000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd4, 32'h6000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b1, 4'd8, 32'h7000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd8, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{1'b1, 4'd5, 32'h8000, 1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd8, 32'h7000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd8, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[19] = '{1'b0, 4'd0, 32'h0,    1'b1, 4'd10, 32'h9000, 1'b0, 1'b0, 4'd8, 32'h7000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 4'd0, 32'h0,    1'b0, 4'd0, 32'h0,    1'b0, 1'b0, 4'd8, 32'h7000, 1'b0, 1'b0, 1'b0, 1'b1};

    exp_gs   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    exp_addr = '{32'h100, 32'h101, 32'h102, 32'hC0, 32'h103, 32'h104, 32'h105};
    cpu_pool = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd12};
    snp_pool = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd3, 4'd4, 4'd5, 4'd6, 4'd0, 4'd7, 4'd10};

    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    @(negedge clk) rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 21; i++) begin
      cpu_valid = vecs[i].cv; cpu_op = vecs[i].cop; cpu_addr = vecs[i].ca;
      snp_valid = vecs[i].sv; snp_op = vecs[i].sop; snp_addr = vecs[i].sa;
      llc_hold  = vecs[i].hold;
      cyc();
      chk($sformatf("vec%0d llc_valid", i), 32'(llc_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d llc_op", i), 32'(llc_op), 32'(vecs[i].e_op));
      chk($sformatf("vec%0d llc_addr", i), llc_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d grant_snp", i), 32'(grant_snp), 32'(vecs[i].e_gs));
      chk($sformatf("vec%0d err_illegal", i), 32'(err_illegal), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("vec%0d cpu_ready", i), 32'(cpu_ready), 32'(vecs[i].e_crdy));
    end
    idle_inputs();

    // Starvation guard: one CPU op against a stream of six snoops.
    for (int k = 0; k < 14; k++) begin
      cpu_valid = (k == 0); cpu_op = 4'd0; cpu_addr = 32'hC0;
      snp_valid = (k <= 5); snp_op = 4'd3; snp_addr = 32'h100 + 32'(k);
      cyc();
      if (llc_valid) begin
        got_gs.push_back(int'(grant_snp));
        got_addr.push_back(llc_addr);
      end
    end
    idle_inputs();
    chk("starve grant count", 32'(got_gs.size()), 7);
    for (int g = 0; g < 7 && g < got_gs.size(); g++) begin
      chk($sformatf("starve grant%0d src", g), 32'(got_gs[g]), 32'(exp_gs[g]));
      chk($sformatf("starve grant%0d addr", g), got_addr[g], exp_addr[g]);
    end

    // Fill the CPU FIFO while every command is held, then reset mid-ISSUE.
    for (int k = 0; k < 6; k++) begin
      cpu_valid = 1; cpu_op = 4'd0; cpu_addr = 32'hA00 + 32'(k);
      llc_hold = 1;
      cyc();
    end
    cpu_valid = 0;
    chk("fill cpu_ready", 32'(cpu_ready), 0);
    chk("fill llc_valid", 32'(llc_valid), 1);
    chk("fill llc_addr", llc_addr, 32'hA02);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("midreset");
    @(negedge clk) rst_n = 1'b1;
    llc_hold = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("postreset%0d llc_valid", k), 32'(llc_valid), 0);
      chk($sformatf("postreset%0d busy", k), 32'(busy), 0);
    end

    // Randomised traffic against the queue model.
    model_reset();
    for (int i = 0; i < 600; i++) begin
      cpu_valid = ($urandom_range(0, 99) < 55);
      cpu_op    = cpu_pool[$urandom_range(0, 10)];
      cpu_addr  = $urandom;
      snp_valid = ($urandom_range(0, 99) < 45);
      snp_op    = snp_pool[$urandom_range(0, 10)];
      snp_addr  = $urandom;
      llc_hold  = ($urandom_range(0, 99) < 25);
      model_edge();
      cyc();
      chk($sformatf("rnd%0d llc_valid", i), 32'(llc_valid), 32'(m_issue));
      chk($sformatf("rnd%0d llc_op", i), 32'(llc_op), 32'(m_op));
      chk($sformatf("rnd%0d llc_addr", i), llc_addr, m_addr);
      chk($sformatf("rnd%0d grant_snp", i), 32'(grant_snp), 32'(m_snp));
      chk($sformatf("rnd%0d err_illegal", i), 32'(err_illegal), 32'(m_err));
      chk($sformatf("rnd%0d busy", i), 32'(busy),
          32'((cq.size() > 0) || (sq.size() > 0) || m_issue || m_hold));
      chk($sformatf("rnd%0d cpu_ready", i), 32'(cpu_ready), 32'(cq.size() < DEPTH));
      chk($sformatf("rnd%0d snp_ready", i), 32'(snp_ready), 32'(sq.size() < DEPTH));
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd reset busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/llc_req_arbiter.md
# llc_req_arbiter

Request arbiter and sequencer in front of the LLC model's single command port (`op`/`addr`). It buffers processor-side commands (L1 reads/writes/fetches, clear, print) and bus-snoop commands (snooped read/write/RWIM/invalidate) in two small FIFOs. It picks one command per cycle under a snoop-priority policy with a starvation guard, and it stalls issue while the LLC asserts `hold`.

## Interface
- `ADDR_W`, 32, address width
- `FIFO_DEPTH`, 4, entries per source FIFO (power of 2, ≥2)
- `STARVE_LIMIT`, 3, consecutive snoop grants allowed while CPU FIFO non-empty before a forced CPU grant
- `clk` in 1, single clock, all state on rising edge
- `rst_n` in 1, asynchronous active-low reset
- `cpu_valid` in 1, CPU-side command valid
- `cpu_ready` out 1, CPU FIFO can accept (= !cpu_full)
- `cpu_op` in 4, trace op code
- `cpu_addr` in ADDR_W, command address
- `snp_valid` in 1, snoop-side command valid
- `snp_ready` out 1, snoop FIFO can accept (= !snp_full)
- `snp_op` in 4, trace op code
- `snp_addr` in ADDR_W, command address
- `llc_valid` out 1, command presented to LLC this cycle
- `llc_op` out 4, op to LLC
- `llc_addr` out ADDR_W, address to LLC
- `llc_hold` in 1, LLC needs one extra cycle for the current command
- `grant_snp` out 1, qualifies `llc_valid`: 1 = snoop source, 0 = CPU
- `err_illegal` out 1, one-cycle pulse: op dropped for wrong port
- `busy` out 1, FIFO non-empty or FSM not IDLE

## Operation
- Legal ops: CPU port 0,1,2,8,9; snoop port 3,4,5,6.
- An illegal op (wrong port, 7, or ≥10) completes its handshake and is not stored. `err_illegal` pulses on the following cycle.
- Push on `valid && ready`. `ready` depends only on full, so a full FIFO refuses a push even in a cycle that pops.
- Barrier: CPU ops 8 (clear) and 9 (print) are eligible only when the snoop FIFO is empty and no snoop is in ISSUE/HOLD.
- Arbitration among eligible heads: snoop wins, unless `starve_cnt == STARVE_LIMIT`, in which case CPU wins.
- `starve_cnt` increments on each snoop grant while the CPU FIFO is non-empty, saturating at STARVE_LIMIT. It clears on a CPU grant or when the CPU FIFO is empty.
- FSM states:
  - IDLE: no command presented.
  - ISSUE: `llc_valid`=1, head popped at the end of the cycle.
  - HOLD: `llc_valid`=0, outputs keep the last op/addr.
- Transitions:
  - IDLE→ISSUE when any head is eligible.
  - ISSUE→HOLD if `llc_hold`=1 at the edge.
  - ISSUE→ISSUE with the next winner if one is eligible, else ISSUE→IDLE.
  - HOLD→ISSUE/IDLE by the same rule after exactly one cycle, regardless of `llc_hold` in HOLD.
- FIFO pointers are (log2 FIFO_DEPTH)+1 bits and wrap modulo 2·FIFO_DEPTH. Full when the MSBs differ and the rest match.

## Timing
- Reset (async assert, sync deassert by system): FIFOs empty, FSM IDLE, `starve_cnt`=0.
- Output values during reset: `llc_valid`=0, `llc_op`=0, `llc_addr`=0, `grant_snp`=0, `err_illegal`=0, `busy`=0, `cpu_ready`=1, `snp_ready`=1.
- Latency: push at edge N into an empty system gives `llc_valid`=1 in cycle N+1 (registered outputs).
- Throughput: one command per cycle with no hold; two cycles per command when held.
- Reset mid-ISSUE/HOLD: in-flight and queued commands are discarded; no partial issue after release.
- Simultaneous push to both ports in one cycle: both accepted if not full.

## Configuration
- `ARB_STATS_EN` defined: adds 32-bit outputs `stat_cpu_grants`, `stat_snp_grants`, `stat_hold_cycles`, `stat_illegal`.
  - All reset to 0, saturate at 2^32-1.
  - Increment on ISSUE per source, per HOLD cycle, and per `err_illegal`.
- `ARB_STATS_EN` undefined: ports and counters are absent; all other behaviour is identical.

## Test plan
- Single CPU op 0 @0x1000 pushed at edge 0 → `llc_valid`=1, op 0, addr 0x1000, `grant_snp`=0 in cycle 1; `busy`=0 by cycle 2.
- CPU op 1 and snoop op 3 pushed in the same cycle → snoop issued first, CPU next cycle.
- CPU FIFO holding one op, 6 snoops queued, STARVE_LIMIT=3 → grant order S,S,S,C,S,S,S.
- `llc_hold`=1 during ISSUE of op 2 → one HOLD cycle with `llc_valid`=0, next command in the following cycle.
- Snoop op 4 queued ahead of CPU op 8 → op 8 not issued until op 4 has left ISSUE; op 5 on CPU port → `err_illegal` pulse, nothing issued.
- Fill CPU FIFO to 4 → `cpu_ready`=0; assert `rst_n`=0 mid-ISSUE → all outputs at reset values immediately, FIFOs empty.
